// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32M types and widths for the multiply/divide unit
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int CNT_W = 5;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;
  typedef enum logic [1:0] {IDLE, CALC, DONE} muldiv_state_e;
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request and write-back signals between core and muldiv unit
interface muldiv_unit_if;
  import riscv_pkg::*;
  logic start;
  logic [2:0] funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0] rd_in;
  logic busy;
  logic wb_valid;
  logic [4:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  modport master(output start, funct3, rs1_data, rs2_data, rd_in, input busy, wb_valid, wb_rd, wb_data);
  modport slave(input start, funct3, rs1_data, rs2_data, rd_in, output busy, wb_valid, wb_rd, wb_data);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per cycle, shared datapath
module muldiv_unit
  import riscv_pkg::*;
(
  input logic clock,
  input logic reset_n,
  muldiv_unit_if.slave bus
);
  muldiv_state_e state, state_nx;
  muldiv_op_e op, f;
  logic [4:0] rd;
  logic neg, accept, a_sgn, b_sgn, dz, ovf, special;
  logic [CNT_W-1:0] cnt;
  logic [63:0] acc, acc_nx, v64, s64;
  logic [XLEN-1:0] sreg, res, wb_data, a_mag, b_mag, spec_res;
  logic [32:0] t;
  logic [33:0] alu;
  assign f = muldiv_op_e'(bus.funct3);
  assign accept = bus.start && state == IDLE;
  assign a_sgn = !(f == OP_MULHU || f == OP_DIVU || f == OP_REMU) && bus.rs1_data[XLEN-1];
  assign b_sgn = (f == OP_MUL || f == OP_MULH || f == OP_DIV || f == OP_REM) && bus.rs2_data[XLEN-1];
  assign a_mag = a_sgn ? -bus.rs1_data : bus.rs1_data;
  assign b_mag = b_sgn ? -bus.rs2_data : bus.rs2_data;
  assign dz = f[2] && bus.rs2_data == '0;
  assign ovf = (f == OP_DIV || f == OP_REM) && bus.rs1_data == 32'h8000_0000 && bus.rs2_data == '1;
  assign special = dz || ovf;
  assign spec_res = dz ? (f[1] ? bus.rs1_data : '1) : (f[1] ? '0 : 32'h8000_0000);
  always_comb begin
    state_nx = state == IDLE ? (accept ? (special ? DONE : CALC) : IDLE)
             : state == CALC ? (&cnt ? DONE : CALC) : IDLE;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  // Multiply shifts right adding into the high half; divide shifts left through a restoring subtract.
  always_comb begin
    t = {acc[63:32], acc[31]};
    alu = op[2] ? {1'b0, t} - {2'b0, sreg} : {2'b0, acc[63:32]} + {2'b0, sreg};
    acc_nx = op[2] ? (alu[33] ? {t[31:0], acc[30:0], 1'b0} : {alu[31:0], acc[30:0], 1'b1})
           : (acc[0] ? {alu[32:0], acc[31:1]} : {1'b0, acc[63:1]});
    v64 = op[2] ? {32'b0, op[1] ? acc_nx[63:32] : acc_nx[31:0]} : acc_nx;
    s64 = neg ? -v64 : v64;
    res = (op[2] || op == OP_MUL) ? s64[31:0] : s64[63:32];
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      op <= OP_MUL;
      rd <= '0;
      neg <= 1'b0;
      cnt <= '0;
      acc <= '0;
      sreg <= '0;
      wb_data <= '0;
    end else if (accept) begin
      op <= f;
      rd <= bus.rd_in;
      cnt <= '0;
      neg <= f == OP_REM ? a_sgn : a_sgn ^ b_sgn;
      acc <= {32'b0, f[2] ? a_mag : b_mag};
      sreg <= f[2] ? b_mag : a_mag;
      if (special) wb_data <= spec_res;
    end else if (state == CALC) begin
      acc <= acc_nx;
      cnt <= cnt + 1'b1;
      if (&cnt) wb_data <= res;
    end
  assign bus.busy = state != IDLE;
  assign bus.wb_valid = state == DONE && rd != '0;
  assign bus.wb_rd = rd;
  assign bus.wb_data = wb_data;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with a queue scoreboard checked on wb_valid
module tb_muldiv_unit;
  typedef struct {
    logic [4:0] rd;
    logic [31:0] data;
  } exp_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  exp_t sb[$];
  muldiv_unit_if bus();
  muldiv_unit dut(.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && bus.wb_valid) begin
      if (sb.size() == 0) check(1'b0, "unexpected_wb", bus.wb_data, 32'h0);
      else begin
        e = sb.pop_front();
        check(bus.wb_data == e.data, "wb_data", bus.wb_data, e.data);
        check(bus.wb_rd == e.rd, "wb_rd", 32'(bus.wb_rd), 32'(e.rd));
      end
    end
  end
  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp, input int wb_n, input bit glitch);
    int n;
    int seen;
    @(negedge clock);
    bus.start = 1'b1;
    bus.funct3 = f;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_in = rd;
    if (rd != 0) sb.push_back('{rd, exp});
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    n = 0;
    seen = -1;
    while (bus.busy && n < 100) begin
      if (bus.wb_valid && seen < 0) seen = n;
      if (glitch && n == 5) begin
        bus.start = 1'b1;
        bus.funct3 = 3'b011;
        bus.rs1_data = 32'h0000_1234;
        bus.rs2_data = 32'h0000_0005;
        bus.rd_in = 5'd9;
      end else bus.start = 1'b0;
      @(posedge clock);
      #1;
      n++;
    end
    bus.start = 1'b0;
    check(n == wb_n + 1, "busy_len", 32'(n), 32'(wb_n + 1));
    check(seen == (rd != 0 ? wb_n : -1), "wb_latency", 32'(seen), rd != 0 ? 32'(wb_n) : 32'hFFFF_FFFF);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    bus.start = 1'b0;
    bus.funct3 = 3'b000;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.rd_in = '0;
    #16;
    check(bus.busy == 1'b0, "rst_busy", 32'(bus.busy), 32'h0);
    check(bus.wb_valid == 1'b0, "rst_wb_valid", 32'(bus.wb_valid), 32'h0);
    check(bus.wb_rd == 5'd0, "rst_wb_rd", 32'(bus.wb_rd), 32'h0);
    check(bus.wb_data == 32'h0, "rst_wb_data", bus.wb_data, 32'h0);
    #4 reset_n = 1'b1;
    run(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 32, 1'b0);
    run(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 32, 1'b0);
    run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE, 32, 1'b0);
    run(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd6, 32'hFFFF_FFFF, 32, 1'b0);
    run(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 32, 1'b0);
    run(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 32, 1'b0);
    run(3'b101, 32'd100, 32'd7, 5'd10, 32'd14, 32, 1'b0);
    run(3'b111, 32'd100, 32'd7, 5'd11, 32'd2, 32, 1'b0);
    run(3'b100, 32'd100, 32'hFFFF_FFF9, 5'd12, 32'hFFFF_FFF2, 32, 1'b0);
    run(3'b110, 32'hFFFF_FF9C, 32'd7, 5'd13, 32'hFFFF_FFFE, 32, 1'b0);
    run(3'b100, 32'd7, 32'd0, 5'd14, 32'hFFFF_FFFF, 0, 1'b0);
    run(3'b110, 32'd7, 32'd0, 5'd15, 32'd7, 0, 1'b0);
    run(3'b111, 32'd5, 32'd0, 5'd16, 32'd5, 0, 1'b0);
    run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 0, 1'b0);
    run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h0, 0, 1'b0);
    run(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd19, 32'hFFFF_FFEB, 32, 1'b1);
    run(3'b000, 32'd3, 32'd4, 5'd0, 32'd12, 32, 1'b0);
    @(negedge clock);
    bus.start = 1'b1;
    bus.funct3 = 3'b000;
    bus.rs1_data = 32'h0000_1111;
    bus.rs2_data = 32'd3;
    bus.rd_in = 5'd20;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (10) begin
      @(posedge clock);
      #1;
    end
    reset_n = 1'b0;
    #1;
    check(bus.busy == 1'b0, "abort_busy", 32'(bus.busy), 32'h0);
    check(bus.wb_valid == 1'b0, "abort_wb_valid", 32'(bus.wb_valid), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    run(3'b000, 32'd5, 32'd6, 5'd21, 32'd30, 32, 1'b0);
    repeat (3) @(posedge clock);
    check(sb.size() == 0, "sb_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
